// File: rtl/crc22_frame_seq_pkg.sv
// Shared definitions for the CRC-22 (x^22 + x + 1) frame sequencer:
// state encoding, default trailer markers and the 16-bit parallel CRC step.
// Optional feature macro used by the top level: CRCSEQ_WDCNT_EN.
package crc22_frame_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DATA  = 3'd1,
        ST_WDCNT = 3'd2,
        ST_CRC0  = 3'd3,
        ST_CRC1  = 3'd4
    } seqState_t;

    localparam logic [4:0] DEFAULT_MARKER     = 5'b11010;
    localparam logic [3:0] DEFAULT_WDCNT_MARK = 4'hE;

    // Parallel CRC22_D16 step: data[15] is the first serial bit, so the
    // loop walks the word MSB-first through the serial LFSR.
    function automatic logic [21:0] nextCRC22_D16(input logic [15:0] data,
                                                  input logic [21:0] crc);
        logic [21:0] c;
        logic        fb;
        c = crc;
        for (int i = 15; i >= 0; i--) begin
            fb   = c[21] ^ data[i];
            c    = {c[20:0], 1'b0};
            c[0] = fb;
            c[1] = c[1] ^ fb;
        end
        return c;
    endfunction

endpackage

// File: rtl/crc22_frame_seq_ce.sv
// CRC-22 accumulator with clock enable and a start input that seeds the
// update from zero, so the register can stall under output backpressure.
module crc22_ce
    import crc22_frame_seq_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        start,
    input  logic [15:0] data,
    output logic [21:0] crc
);

    // Fold one 16-bit word into the CRC when enabled; start restarts from zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            crc <= '0;
        end else if (enable) begin
            crc <= nextCRC22_D16(data, start ? 22'd0 : crc);
        end
    end

endmodule

// File: rtl/crc22_frame_seq.sv
// Frame sequencer: forwards a first/last-delimited 16-bit word stream through
// a one-stage valid/ready register, accumulates CRC-22 over the data words
// and appends two trailer words {MARKER, crc half}.
// Optional feature macro: CRCSEQ_WDCNT_EN adds a {WDCNT_MARK, count} trailer
// word ahead of the CRC words.
module crc22_frame_seq
    import crc22_frame_seq_pkg::*;
#(
    parameter logic [4:0] MARKER     = DEFAULT_MARKER,
    parameter logic [3:0] WDCNT_MARK = DEFAULT_WDCNT_MARK
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] in_data,
    input  logic        in_first,
    input  logic        in_last,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] out_data,
    output logic        out_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [21:0] crc_out,
    output logic        frame_done,
    output logic        frame_err
);

    seqState_t   state;
    seqState_t   stateNext;
    logic        slotFree;
    logic        acc;
    logic        crcStart;
    logic        framingErr;
    logic [21:0] crc;
    logic        loadEn;
    logic [15:0] loadData;
    logic        loadLast;
    logic        latchCrc;

    assign slotFree   = !out_valid || out_ready;
    assign in_ready   = ((state == ST_IDLE) || (state == ST_DATA)) && slotFree;
    assign acc        = in_valid && in_ready;
    assign crcStart   = (state == ST_IDLE) || in_first;
    assign framingErr = acc && (((state == ST_DATA) && in_first) ||
                                ((state == ST_IDLE) && !in_first));
    assign frame_done = out_valid && out_last && out_ready;

    crc22_ce u_crc (
        .clock  (clock),
        .reset  (reset),
        .enable (acc),
        .start  (crcStart),
        .data   (in_data),
        .crc    (crc)
    );

`ifdef CRCSEQ_WDCNT_EN
    logic [11:0] wordCount;

    // Count data words of the current frame, restarting on a frame start and saturating.
    always_ff @(posedge clock) begin
        if (reset) begin
            wordCount <= '0;
        end else if (acc) begin
            if (crcStart) begin
                wordCount <= 12'd1;
            end else if (wordCount != 12'hFFF) begin
                wordCount <= wordCount + 12'd1;
            end
        end
    end
`else
    logic [3:0] unusedWdcntMark;
    assign unusedWdcntMark = WDCNT_MARK;
`endif

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic and selection of the word to load into the output slot.
    always_comb begin
        stateNext = state;
        loadEn    = 1'b0;
        loadData  = '0;
        loadLast  = 1'b0;
        latchCrc  = 1'b0;
        case (state)
            ST_IDLE, ST_DATA: begin
                if (acc) begin
                    loadEn   = 1'b1;
                    loadData = in_data;
                    if (in_last) begin
`ifdef CRCSEQ_WDCNT_EN
                        stateNext = ST_WDCNT;
`else
                        stateNext = ST_CRC0;
`endif
                    end else begin
                        stateNext = ST_DATA;
                    end
                end
            end
`ifdef CRCSEQ_WDCNT_EN
            ST_WDCNT: begin
                if (slotFree) begin
                    loadEn    = 1'b1;
                    loadData  = {WDCNT_MARK, wordCount};
                    stateNext = ST_CRC0;
                end
            end
`endif
            ST_CRC0: begin
                if (slotFree) begin
                    loadEn    = 1'b1;
                    loadData  = {MARKER, crc[10:0]};
                    stateNext = ST_CRC1;
                end
            end
            ST_CRC1: begin
                if (slotFree) begin
                    loadEn    = 1'b1;
                    loadData  = {MARKER, crc[21:11]};
                    loadLast  = 1'b1;
                    latchCrc  = 1'b1;
                    stateNext = ST_IDLE;
                end
            end
            default: begin
                stateNext = ST_IDLE;
            end
        endcase
    end

    // Output slot: load a new word when free, otherwise drop valid once drained.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_data  <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
        end else if (loadEn) begin
            out_data  <= loadData;
            out_last  <= loadLast;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Latch the finished CRC with the last trailer word and register framing-error pulses.
    always_ff @(posedge clock) begin
        if (reset) begin
            crc_out   <= '0;
            frame_err <= 1'b0;
        end else begin
            if (latchCrc) begin
                crc_out <= crc;
            end
            frame_err <= framingErr;
        end
    end

endmodule

// File: doc/crc22_frame_seq.md
# crc22_frame_seq

Frame sequencer for the CRC-22 (x22+x1+1) check on 16-bit DAQ readout words. It sits between the readout word multiplexer and the DAQ output FIFO. It passes a first/last-delimited word stream through a one-stage valid/ready register and accumulates the CRC over every data word of the frame. After the last word it appends two CRC trailer words, each an 11-bit CRC half under a 5-bit marker.

## Interface
Parameters:
- MARKER, 5'b11010, upper 5 bits of each CRC trailer word
- WDCNT_MARK, 4'hE, upper 4 bits of the word-count trailer word (only with CRCSEQ_WDCNT_EN)

Ports:
- clock  in  1  single clock; all state changes on posedge
- reset  in  1  synchronous, active-high; clears all state
- in_data  in  16  readout word
- in_first  in  1  word is the first of a frame
- in_last  in  1  word is the last of a frame
- in_valid  in  1  in_data/flags valid
- in_ready  out  1  block accepts the word this cycle
- out_data  out  16  registered output word
- out_last  out  1  out_data is the final trailer word of the frame
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts out_data this cycle
- crc_out  out  22  CRC of the most recently completed frame
- frame_done  out  1  one-cycle pulse when the final trailer word is accepted
- frame_err  out  1  one-cycle pulse on a framing violation

## Operation
- The states are IDLE, DATA, WDCNT (present only with the macro), CRC0 and CRC1.
- A slot is free when `!out_valid || out_ready`.
- in_ready = (IDLE or DATA) && slot free. A word is accepted when `acc = in_valid && in_ready`.
- On acc, the output register loads the word with out_last = 0.
- CRC update on acc:
  - If the block is in IDLE, or in_first = 1, then crc <= f(in_data, 0).
  - Otherwise crc <= f(in_data, crc).
  - f is the Easics CRC22_D16 function: D[15] is the first serial bit, and NewCRC[17..21] = C[1..5].
- Transitions:
  - IDLE to DATA on acc without in_last.
  - Accepting a word with in_last = 1 moves to CRC0 (or to WDCNT with the macro). This applies from IDLE or DATA.
  - CRC0 loads {MARKER, crc[10:0]} into the output when the slot is free, then moves to CRC1.
  - CRC1 loads {MARKER, crc[21:11]} with out_last = 1, latches crc_out <= crc, then moves to IDLE.
- frame_done pulses when the CRC1 word is accepted downstream (out_valid && out_last && out_ready).
- The CRC covers data words only; trailer words are excluded.
- Framing errors: frame_err pulses, and the offending word is still forwarded, in two cases:
  - in_first = 1 while in DATA. The CRC restarts on this word.
  - A word without in_first is accepted in IDLE. It is treated as first.
- A single-word frame (in_first = in_last = 1) is legal.
- Reset mid-frame:
  - state = IDLE, crc = 0, crc_out = 0.
  - out_valid, out_last, frame_done and frame_err all go to 0. out_data = 0.
  - The partial frame is discarded with no trailer.

## Timing
- Data latency is 1 cycle from acc to out_valid.
- Full throughput: 1 word per cycle while out_ready = 1.
- When the last word is accepted in cycle t (with out_ready held at 1):
  - CRC0 is on out_data in cycle t+2.
  - CRC1 is on out_data in cycle t+3.
  - frame_done pulses in cycle t+3.
  - in_ready is low in cycles t+1 and t+2, then rises in cycle t+3.
  - With the macro, add one cycle to each of the above.
- Backpressure: out_data and flags hold stable while `out_valid && !out_ready`. No word is dropped or duplicated.
- Simultaneous out_ready and a new load in the same cycle is a legal back-to-back transfer.

## Configuration
- Macro: CRCSEQ_WDCNT_EN.
- Defined:
  - A 12-bit data-word counter is reset on the first word and saturates at 4095.
  - The WDCNT state emits {WDCNT_MARK, count} ahead of CRC0.
  - That word is excluded from the CRC.
- Undefined:
  - No counter and no WDCNT state.
  - The trailer is exactly two words.

## Structure
- Shared package contents:
  - State encoding constants.
  - Default MARKER and WDCNT_MARK values.
  - The nextCRC22_D16 function.
- One sub-module: crc22_ce. It is a CRC-22 register with synchronous reset, a clock enable, and a start input that seeds from zero. The existing free-running CRC register has no enable, which backpressure requires.

## Test plan
- Single word 0x0001 with first = last = 1, out_ready = 1 -> outputs are 0x0001, then 0xD003, then 0xD000 with out_last = 1. crc_out = 0x000003 and frame_done pulses.
- Single word 0x8000 -> outputs are 0x8000, 0xD000, 0xD030. crc_out = 0x018000.
- Frame 0x0001 (first) then 0x0000 (last) -> trailer is 0xD000, 0xD060. crc_out = 0x030000. Back-to-back frames follow with no lost cycles beyond the trailer.
- Same frame with out_ready toggled at random -> identical output sequence and no duplicates. in_ready is never high during CRC0/CRC1.
- in_first asserted again mid-frame -> frame_err pulses. The CRC equals that of a fresh frame starting at that word.
- Reset asserted in DATA -> next cycle out_valid = 0 and crc_out = 0. A following 0x0001 single-word frame yields 0xD003, 0xD000.
